// File: rtl/mem_map_pkg.sv
// System memory map shared by the memory system, its address decoders and the write arbiter.
package mem_map_pkg;

    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 32;
    localparam int DISP_START = 256;   // first display-RAM word
    localparam int DISP_END   = 4352;  // one past the last display-RAM word
    localparam int UART_ADDR  = 4353;

endpackage

// File: rtl/mem_wr_arbiter_pkg.sv
// Arbiter-local types and defaults: grant encoding, clear-engine state codes, fill value.
package mem_wr_arbiter_pkg;

    localparam int DEF_BLANK      = 32;  // ASCII space; the memory subtracts 32 on store
    localparam int DEF_STARVE_MAX = 4;

    localparam logic [1:0] CLR_IDLE = 2'd0;
    localparam logic [1:0] CLR_RUN  = 2'd1;
    localparam logic [1:0] CLR_DONE = 2'd2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_CON  = 2'd2,
        GNT_CLR  = 2'd3
    } gnt_e;

endpackage

// File: rtl/mem_wr_arbiter_if.sv
// Requester and memory-port bundle of the write arbiter; slave is the arbiter's view.
interface mem_wr_arbiter_if #(
    parameter int ADDR_W = mem_map_pkg::ADDR_W,
    parameter int DATA_W = mem_map_pkg::DATA_W
);
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;

    logic              con_req;
    logic [ADDR_W-1:0] con_addr;
    logic [DATA_W-1:0] con_wdata;
    logic              con_ack;

    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output cpu_we, cpu_addr, cpu_wdata,
        output con_req, con_addr, con_wdata,
        output clr_start,
        input  cpu_stall, con_ack, clr_busy, clr_done,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_we, cpu_addr, cpu_wdata,
        input  con_req, con_addr, con_wdata,
        input  clr_start,
        output cpu_stall, con_ack, clr_busy, clr_done,
        output mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/disp_clear_engine.sv
// Display blank-fill sequencer: walks a pointer across the display RAM, one word per grant.
module disp_clear_engine
    import mem_wr_arbiter_pkg::*;
#(
    parameter int ADDR_W     = mem_map_pkg::ADDR_W,
    parameter int DISP_START = mem_map_pkg::DISP_START,
    parameter int DISP_END   = mem_map_pkg::DISP_END
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_start,
    input  logic              clr_gnt,
    output logic              clr_req,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(DISP_START);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DISP_END - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        // A restart wins over everything, including the final-word transition.
        if (clr_start) begin
            state_d = CLR_RUN;
            ptr_d   = PTR_FIRST;
        end else begin
            case (state_q)
                CLR_IDLE: state_d = CLR_IDLE;
                CLR_RUN: begin
                    if (clr_gnt) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                        if (ptr_q == PTR_LAST) begin
                            state_d = CLR_DONE;
                        end
                    end
                end
                CLR_DONE: state_d = CLR_IDLE;
                default:  state_d = CLR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLR_IDLE;
            ptr_q   <= PTR_FIRST;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign clr_req  = (state_q == CLR_RUN);
    assign clr_addr = ptr_q;
    assign clr_busy = (state_q == CLR_RUN) || (state_q == CLR_DONE);
    assign clr_done = (state_q == CLR_DONE);

endmodule

// File: rtl/mem_wr_arbiter.sv
// Single memory write port shared by CPU stores, the console writer and the display clear;
// fixed priority CPU > console > clear, with a starvation override for the console.
module mem_wr_arbiter
    import mem_wr_arbiter_pkg::*;
#(
    parameter int ADDR_W     = mem_map_pkg::ADDR_W,
    parameter int DATA_W     = mem_map_pkg::DATA_W,
    parameter int DISP_START = mem_map_pkg::DISP_START,
    parameter int DISP_END   = mem_map_pkg::DISP_END,
    parameter int BLANK      = DEF_BLANK,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic           clk,
    input  logic           rst,
    mem_wr_arbiter_if.slave bus
);

    localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_TOP = CNT_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] DISP_LO    = ADDR_W'(DISP_START);
    localparam logic [ADDR_W-1:0] DISP_HI    = ADDR_W'(DISP_END);

    logic              clr_req;
    logic              clr_gnt;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_busy;
    logic              clr_done;

    logic              con_in_disp;
    logic              con_elig;
    logic              con_force;
    gnt_e              gnt;

    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              con_ack_q, con_ack_d;

    disp_clear_engine #(
        .ADDR_W     (ADDR_W),
        .DISP_START (DISP_START),
        .DISP_END   (DISP_END)
    ) u_clear (
        .clk       (clk),
        .rst       (rst),
        .clr_start (bus.clr_start),
        .clr_gnt   (clr_gnt),
        .clr_req   (clr_req),
        .clr_addr  (clr_addr),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    // The console request is still held high during its ack cycle, so that cycle is masked.
    // Display-range console writes wait out a clear so they are not overwritten by blanks.
    always_comb begin
        con_in_disp = (bus.con_addr >= DISP_LO) && (bus.con_addr < DISP_HI);
        con_elig    = bus.con_req && !con_ack_q && !(clr_busy && con_in_disp);
        con_force   = con_elig && (starve_q == STARVE_TOP);

        gnt = GNT_NONE;
        if (bus.cpu_we && !con_force) begin
            gnt = GNT_CPU;
        end else if (con_elig) begin
            gnt = GNT_CON;
        end else if (clr_req) begin
            gnt = GNT_CLR;
        end
    end

    assign clr_gnt       = (gnt == GNT_CLR);
    assign bus.cpu_stall = bus.cpu_we && (gnt != GNT_CPU);

    always_comb begin
        starve_d = starve_q;
        if (!con_elig || gnt == GNT_CON) begin
            starve_d = '0;
        end else if (gnt == GNT_CPU && starve_q != STARVE_TOP) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_comb begin
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        con_ack_d   = (gnt == GNT_CON);
        case (gnt)
            GNT_CPU: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = bus.cpu_addr;
                mem_wdata_d = bus.cpu_wdata;
            end
            GNT_CON: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = bus.con_addr;
                mem_wdata_d = bus.con_wdata;
            end
            GNT_CLR: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = clr_addr;
                mem_wdata_d = DATA_W'(BLANK);
            end
            default: mem_we_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            con_ack_q   <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            con_ack_q   <= con_ack_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.con_ack   = con_ack_q;
    assign bus.clr_busy  = clr_busy;
    assign bus.clr_done  = clr_done;

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Scoreboard bench for mem_wr_arbiter: stimulus queues expected memory writes, a monitor
// pops and compares each write as it appears on the memory port.
module tb_mem_wr_arbiter;

    typedef struct packed {
        logic [12:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;

    always #5 clk = ~clk;

    mem_wr_arbiter_if bus_if ();

    mem_wr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int addr, input logic [31:0] data);
        wr_t w;
        w.addr = 13'(addr);
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic push_clear(input int lo, input int hi);
        for (int a = lo; a < hi; a++) push(a, 32'd32);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Memory-port monitor
    always @(negedge clk) begin
        if (rst !== 1'b1 && bus_if.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         bus_if.mem_addr, bus_if.mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mem_write", 64'({bus_if.mem_addr, bus_if.mem_wdata}),
                    64'({mon_e.addr, mon_e.data}));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt, done_cnt, we_cnt, end_k, done_k, ack_k;

        bus_if.cpu_we    = 1'b0;
        bus_if.cpu_addr  = '0;
        bus_if.cpu_wdata = '0;
        bus_if.con_req   = 1'b0;
        bus_if.con_addr  = '0;
        bus_if.con_wdata = '0;
        bus_if.clr_start = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_we",    64'(bus_if.mem_we),    64'(0));
        chk("rst_mem_addr",  64'(bus_if.mem_addr),  64'(0));
        chk("rst_mem_wdata", 64'(bus_if.mem_wdata), 64'(0));
        chk("rst_con_ack",   64'(bus_if.con_ack),   64'(0));
        chk("rst_clr_busy",  64'(bus_if.clr_busy),  64'(0));
        chk("rst_clr_done",  64'(bus_if.clr_done),  64'(0));
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // CPU alone
        bus_if.cpu_we    = 1'b1;
        bus_if.cpu_addr  = 13'h010;
        bus_if.cpu_wdata = 32'hDEADBEEF;
        push(32'h010, 32'hDEADBEEF);
        $display("[TB] cpu write addr 010 data deadbeef");
        @(negedge clk);
        chk("cpu_alone_stall", 64'(bus_if.cpu_stall), 64'(0));
        next_cycle();
        bus_if.cpu_we = 1'b0;
        @(negedge clk);
        chk("cpu_alone_we", 64'(bus_if.mem_we), 64'(1));
        next_cycle();

        // CPU vs console: four CPU wins, then the console is forced through
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            bus_if.cpu_we    = 1'b1;
            bus_if.cpu_addr  = 13'(32'h100 + k);
            bus_if.cpu_wdata = 32'hC0DE0000 + 32'(k);
            bus_if.con_req   = (k <= 5);
            bus_if.con_addr  = 13'h00A;
            bus_if.con_wdata = 32'h12345678;
            if (k == 4) push(32'h00A, 32'h12345678);
            else        push(32'h100 + k, 32'hC0DE0000 + 32'(k));
            $display("[TB] contention cycle %0d", k);
            @(negedge clk);
            chk("starve_stall", 64'(bus_if.cpu_stall), 64'(k == 4));
            chk("starve_ack",   64'(bus_if.con_ack),   64'(k == 5));
        end
        next_cycle();
        bus_if.cpu_we  = 1'b0;
        bus_if.con_req = 1'b0;
        @(negedge clk);
        chk("ack_single", 64'(bus_if.con_ack), 64'(0));
        repeat (2) next_cycle();

        // Full uncontended clear
        bus_if.clr_start = 1'b1;
        push_clear(256, 4352);
        $display("[TB] full clear started");
        @(negedge clk);
        busy_cnt = 0; done_cnt = 0; we_cnt = 0; end_k = -1;
        for (int k = 1; k < 4300; k++) begin
            next_cycle();
            bus_if.clr_start = 1'b0;
            @(negedge clk);
            if (bus_if.clr_busy) busy_cnt++;
            if (bus_if.clr_done) begin
                done_cnt++;
                chk("done_last_write", 64'({bus_if.mem_we, bus_if.mem_addr}),
                    64'({1'b1, 13'd4351}));
            end
            if (bus_if.mem_we) we_cnt++;
            if (!bus_if.clr_busy) begin
                end_k = k;
                break;
            end
        end
        chk("clear_busy_cycles", 64'(busy_cnt), 64'(4097));
        chk("clear_done_count",  64'(done_cnt), 64'(1));
        chk("clear_writes",      64'(we_cnt),   64'(4096));
        chk("clear_end_cycle",   64'(end_k),    64'(4098));
        next_cycle();

        // Clear with console traffic
        bus_if.clr_start = 1'b1;
        push_clear(256, 265);
        push(5, 32'hAAAA0005);
        push_clear(265, 4352);
        push(300, 32'hAAAA012C);
        $display("[TB] clear with console started");
        @(negedge clk);
        for (int k = 1; k < 10; k++) begin
            next_cycle();
            bus_if.clr_start = 1'b0;
        end
        next_cycle();
        bus_if.con_req   = 1'b1;
        bus_if.con_addr  = 13'd5;
        bus_if.con_wdata = 32'hAAAA0005;
        $display("[TB] console write addr 5 during clear");
        next_cycle();
        @(negedge clk);
        chk("con_outside_ack", 64'(bus_if.con_ack), 64'(1));
        next_cycle();
        bus_if.con_addr  = 13'd300;
        bus_if.con_wdata = 32'hAAAA012C;
        $display("[TB] console write addr 300 during clear");
        done_k = -1; ack_k = -1;
        for (int k = 12; k < 4200; k++) begin
            if (k > 12) next_cycle();
            @(negedge clk);
            if (bus_if.clr_done) done_k = k;
            if (bus_if.con_ack) begin
                ack_k = k;
                break;
            end
        end
        chk("held_done_cycle", 64'(done_k), 64'(4098));
        chk("held_ack_cycle",  64'(ack_k),  64'(4100));
        next_cycle();
        bus_if.con_req = 1'b0;
        next_cycle();

        // Restart at pointer 1000
        bus_if.clr_start = 1'b1;
        push_clear(256, 1001);
        push_clear(256, 4352);
        $display("[TB] clear with restart started");
        @(negedge clk);
        done_cnt = 0; end_k = -1;
        for (int k = 1; k < 5000; k++) begin
            next_cycle();
            bus_if.clr_start = (k == 745);
            @(negedge clk);
            if (bus_if.clr_done) done_cnt++;
            if (!bus_if.clr_busy) begin
                end_k = k;
                break;
            end
        end
        chk("restart_done_count", 64'(done_cnt), 64'(1));
        chk("restart_end_cycle",  64'(end_k),    64'(4843));
        next_cycle();

        // Reset in the middle of a clear with the CPU writing
        bus_if.clr_start = 1'b1;
        push_clear(256, 275);
        $display("[TB] clear then reset");
        @(negedge clk);
        for (int k = 1; k < 30; k++) begin
            next_cycle();
            bus_if.clr_start = 1'b0;
            if (k >= 20) begin
                bus_if.cpu_we    = 1'b1;
                bus_if.cpu_addr  = 13'(32'h020 + k);
                bus_if.cpu_wdata = 32'hBEEF0000 + 32'(k);
                push(32'h020 + k, 32'hBEEF0000 + 32'(k));
            end
            @(negedge clk);
        end
        next_cycle();
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_mem_we",    64'(bus_if.mem_we),    64'(0));
        chk("mid_rst_mem_addr",  64'(bus_if.mem_addr),  64'(0));
        chk("mid_rst_mem_wdata", 64'(bus_if.mem_wdata), 64'(0));
        chk("mid_rst_con_ack",   64'(bus_if.con_ack),   64'(0));
        chk("mid_rst_clr_busy",  64'(bus_if.clr_busy),  64'(0));
        chk("mid_rst_clr_done",  64'(bus_if.clr_done),  64'(0));
        bus_if.cpu_we = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            next_cycle();
            @(negedge clk);
            if (bus_if.clr_busy) busy_cnt++;
            if (bus_if.clr_done) done_cnt++;
        end
        chk("post_rst_busy", 64'(busy_cnt), 64'(0));
        chk("post_rst_done", 64'(done_cnt), 64'(0));

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_wr_arbiter.md
Name: mem_wr_arbiter

Overview:
- Shares the single memory-system write port (we / write_addr / write_data) between three requesters: CPU stores, the console writer (UART-to-screen text path) and an internal display-clear engine.
- Sits between the CPU/console logic and the memory system, and drives its write-side inputs directly.
- Grants one write per cycle with fixed priority plus console anti-starvation.
- Sequences a full-screen blank fill of the display RAM on command.

Parameters:
- ADDR_W, 13, write address width.
- DATA_W, 32, write data width.
- DISP_START, 256, first display-RAM word address.
- DISP_END, 4352, one past the last display-RAM word address.
- BLANK, 32, data value written by the clear engine (ASCII space; stored as 0 after the memory's -32 offset).
- STARVE_MAX, 4, number of consecutive console losses to the CPU before the console is forced to win.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cpu_we  in  1  CPU write request; held while cpu_stall=1.
- cpu_addr  in  ADDR_W  CPU write address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  combinational; 1 = CPU request not granted this cycle.
- con_req  in  1  console write request; held until con_ack.
- con_addr  in  ADDR_W  console write address.
- con_wdata  in  DATA_W  console write data.
- con_ack  out  1  registered one-cycle pulse; the console write is on the memory port this cycle.
- clr_start  in  1  single-cycle pulse starting the display clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.
- mem_we  out  1  registered write enable to the memory.
- mem_addr  out  ADDR_W  registered write address.
- mem_wdata  out  DATA_W  registered write data.

Behaviour:
- Reset (asynchronous, any state): mem_we=0, mem_addr=0, mem_wdata=0, con_ack=0, clr_busy=0, clr_done=0, starve counter=0, clear FSM=IDLE, clear pointer=DISP_START. A clear in progress is abandoned with no clr_done.
- Grant decision (combinational, each cycle). Eligible requests:
  - CPU when cpu_we=1.
  - Console when con_req=1 and con_ack=0 (masks the held request in its ack cycle), and not (clr_busy and DISP_START<=con_addr<DISP_END).
  - Clear when FSM=CLEAR.
- Priority: CPU > console > clear. Exception: when starve counter = STARVE_MAX and the console is eligible, the console wins over the CPU.
- cpu_stall = cpu_we and not granted.
- Starve counter:
  - +1 (saturating at STARVE_MAX) on each cycle the console is eligible and the CPU wins.
  - Cleared on a console grant, and on any cycle the console is not eligible.
- Latency: the granted request is registered onto mem_we/mem_addr/mem_wdata at the next clk edge. con_ack is asserted in that same cycle. mem_we=0 in the cycle after a no-grant cycle.
- Console writes into the display range during a clear are held, not dropped, and granted after clr_done. Console writes outside the display range proceed during a clear.
- Clear FSM:
  - IDLE: clr_start -> CLEAR, pointer=DISP_START.
  - CLEAR: on a clear grant, issue (pointer, BLANK) and increment the pointer. The grant for pointer=DISP_END-1 -> DONE.
  - DONE: clr_done=1 for one cycle -> IDLE.
  - clr_busy=1 in CLEAR and DONE.
  - clr_start in CLEAR or DONE: pointer reloads to DISP_START, state becomes CLEAR, and no clr_done is issued for the aborted pass. This takes precedence over the last-write transition.
- An uncontended clear takes DISP_END-DISP_START = 4096 cycles of grants, plus 1 cycle in DONE.
- Address and data pass through unmodified. The arbiter does no range checking except the display-range hold rule.

Decomposition:
- Shared package mem_map_pkg holds ADDR_W, DATA_W, DISP_START, DISP_END and UART_ADDR (4353), for reuse by the memory system and its decoders.
- One natural sub-module, disp_clear_engine: the clear FSM and pointer, with a request/grant interface to the arbiter core.
- Priority logic, starve counter and output registers stay in the top level.

Test Plan:
- Reset: assert rst mid-clear with cpu_we=1 -> all outputs 0 immediately; after release, clr_busy=0 and no clr_done ever pulses.
- CPU alone: cpu_we=1, addr=0x010, data=0xDEADBEEF -> cpu_stall=0; next cycle mem_we=1, mem_addr=0x010, mem_wdata=0xDEADBEEF.
- Contention and starvation: cpu_we held 1 every cycle and con_req=1 at addr=0x00A, STARVE_MAX=4 -> 4 CPU grants, then con_ack pulse with mem_addr=0x00A; cpu_stall=1 exactly in the console-grant cycle; con_ack high for exactly 1 cycle.
- Full clear: clr_start pulse with no other traffic -> 4096 consecutive writes, addresses 256..4351, data 32, then clr_done one cycle after the last write; clr_busy spans 4097 cycles.
- Clear with console: during a clear, con_req at addr 300 is held until after clr_done, then written; con_req at addr 5 is granted within 1 cycle and preempts one clear write, and the pointer does not skip.
- Restart: clr_start issued when the pointer reaches 1000 -> the next clear write is at 256; exactly one clr_done, after 4096 further clear writes.
